// File: rtl/sd_pkg.sv
// Shared encodings for the SD card SPI-mode command sequencer and its engine.
package sd_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'h0,
    StPwrup  = 4'h1,
    StCmd0   = 4'h2,
    StCmd8   = 4'h3,
    StCmd55  = 4'h4,
    StAcmd41 = 4'h5,
    StWait   = 4'h6,
    StCmd58  = 4'h7,
    StCmd16  = 4'h8,
    StReady  = 4'h9,
    StCmd17  = 4'hA,
    StData   = 4'hB,
    StError  = 4'hC
  } state_e;

  localparam logic [5:0] Cmd0Idx   = 6'd0;
  localparam logic [5:0] Cmd8Idx   = 6'd8;
  localparam logic [5:0] Cmd16Idx  = 6'd16;
  localparam logic [5:0] Cmd17Idx  = 6'd17;
  localparam logic [5:0] Cmd55Idx  = 6'd55;
  localparam logic [5:0] Acmd41Idx = 6'd41;
  localparam logic [5:0] Cmd58Idx  = 6'd58;

  localparam logic [6:0] Crc0    = 7'h4A;
  localparam logic [6:0] Crc8    = 7'h43;
  localparam logic [6:0] CrcNone = 7'h7F;

  localparam logic [3:0] ErrCmd0    = 4'd1;
  localparam logic [3:0] ErrCmd8    = 4'd2;
  localparam logic [3:0] ErrAcmd41  = 4'd3;
  localparam logic [3:0] ErrCmd58   = 4'd4;
  localparam logic [3:0] ErrCmd16   = 4'd5;
  localparam logic [3:0] ErrCmd17   = 4'd6;
  localparam logic [3:0] ErrData    = 4'd7;
  localparam logic [3:0] ErrTimeout = 4'd8;

  localparam logic [11:0] Cmd8Pattern = 12'h1AA;

  function automatic logic is_cmd_state(state_e s);
    return (s == StCmd0) || (s == StCmd8) || (s == StCmd55) || (s == StAcmd41) ||
           (s == StCmd58) || (s == StCmd16) || (s == StCmd17);
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer.sv
// SPI-mode SD card initialisation and CMD17 single-block read sequencer.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned CMD0_RETRIES   = 8,
  parameter int unsigned ACMD41_RETRIES = 1000,
  parameter int unsigned RETRY_WAIT     = 27000
) (
  input  logic        CLOCK_27,
  input  logic        RST,
  input  logic        start,
  output logic        pwrup_req,
  input  logic        pwrup_done,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  output logic        cmd_long,
  input  logic        resp_valid,
  input  logic        resp_timeout,
  input  logic [7:0]  resp_r1,
  input  logic [31:0] resp_data,
  output logic        spi_fast,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ack,
  output logic        data_start,
  input  logic        data_done,
  input  logic        data_err,
  output logic        ready,
  output logic        busy,
  output logic        error,
  output logic [3:0]  err_code,
  output logic        sdhc,
  output logic [3:0]  state_out
);

  state_e      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d, cmd_sent_q, cmd_sent_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d, rd_arg_q, rd_arg_d, wait_cnt_q, wait_cnt_d;
  logic [6:0]  cmd_crc_q, cmd_crc_d;
  logic        cmd_long_q, cmd_long_d;
  logic [15:0] cmd0_cnt_q, cmd0_cnt_d, acmd_cnt_q, acmd_cnt_d;
  logic        hcs_q, hcs_d, sdhc_q, sdhc_d, spi_fast_q, spi_fast_d;
  logic        rd_ack_q, rd_ack_d, data_start_q, data_start_d;
  logic [3:0]  err_code_q, err_code_d, err_set;
  logic        resp_ok, resp_to;

  // Responses only count while a command has been accepted and not yet answered.
  assign resp_to = cmd_sent_q & resp_timeout;
  assign resp_ok = cmd_sent_q & resp_valid & ~resp_timeout;

  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_sent_d   = cmd_sent_q;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;
    cmd_crc_d    = cmd_crc_q;
    cmd_long_d   = cmd_long_q;
    rd_arg_d     = rd_arg_q;
    wait_cnt_d   = wait_cnt_q;
    cmd0_cnt_d   = cmd0_cnt_q;
    acmd_cnt_d   = acmd_cnt_q;
    hcs_d        = hcs_q;
    sdhc_d       = sdhc_q;
    spi_fast_d   = spi_fast_q;
    err_code_d   = err_code_q;
    rd_ack_d     = 1'b0;
    data_start_d = 1'b0;
    err_set      = 4'd0;

    if (is_cmd_state(state_q) && !cmd_valid_q && !cmd_sent_q) begin
      cmd_valid_d = 1'b1;
      cmd_arg_d   = 32'd0;
      cmd_crc_d   = CrcNone;
      cmd_long_d  = 1'b0;
      case (state_q)
        StCmd0:   begin cmd_index_d = Cmd0Idx; cmd_crc_d = Crc0; end
        StCmd8:   begin
          cmd_index_d = Cmd8Idx;
          cmd_arg_d   = {20'd0, Cmd8Pattern};
          cmd_crc_d   = Crc8;
          cmd_long_d  = 1'b1;
        end
        StCmd55:  cmd_index_d = Cmd55Idx;
        StAcmd41: begin cmd_index_d = Acmd41Idx; cmd_arg_d = {1'b0, hcs_q, 30'd0}; end
        StCmd58:  begin cmd_index_d = Cmd58Idx; cmd_long_d = 1'b1; end
        StCmd16:  begin cmd_index_d = Cmd16Idx; cmd_arg_d = 32'd512; end
        default:  begin cmd_index_d = Cmd17Idx; cmd_arg_d = rd_arg_q; end
      endcase
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      cmd_sent_d  = 1'b1;
    end

    if (resp_ok || resp_to) cmd_sent_d = 1'b0;

    case (state_q)
      StIdle: ;
      StPwrup: if (pwrup_done) state_d = StCmd0;
      StCmd0: begin
        if (resp_ok && resp_r1 == 8'h01) begin
          state_d = StCmd8;
        end else if (resp_ok || resp_to) begin
          if (32'(cmd0_cnt_q) + 32'd1 >= CMD0_RETRIES) err_set = ErrCmd0;
          else cmd0_cnt_d = cmd0_cnt_q + 16'd1;
        end
      end
      StCmd8: begin
        if (resp_to) err_set = ErrTimeout;
        else if (resp_ok) begin
          if (resp_r1 == 8'h01 && resp_data[11:0] == Cmd8Pattern) begin
            hcs_d = 1'b1; state_d = StCmd55;
          end else if (resp_r1 == 8'h05) begin
            hcs_d = 1'b0; state_d = StCmd55;
          end else err_set = ErrCmd8;
        end
      end
      StCmd55: begin
        if (resp_to) err_set = ErrTimeout;
        else if (resp_ok) begin
          if (resp_r1 == 8'h00 || resp_r1 == 8'h01) state_d = StAcmd41;
          else err_set = ErrAcmd41;
        end
      end
      StAcmd41: begin
        if (resp_to) err_set = ErrTimeout;
        else if (resp_ok) begin
          if (resp_r1 == 8'h00) state_d = StCmd58;
          else if (resp_r1 == 8'h01 && 32'(acmd_cnt_q) + 32'd1 < ACMD41_RETRIES) begin
            acmd_cnt_d = acmd_cnt_q + 16'd1;
            wait_cnt_d = RETRY_WAIT - 32'd1;
            state_d    = StWait;
          end else err_set = ErrAcmd41;
        end
      end
      StWait: begin
        if (wait_cnt_q == 32'd0) state_d = StCmd55;
        else wait_cnt_d = wait_cnt_q - 32'd1;
      end
      StCmd58: begin
        if (resp_to) err_set = ErrTimeout;
        else if (resp_ok) begin
          if (resp_r1 != 8'h00) err_set = ErrCmd58;
          else begin
            sdhc_d  = hcs_q & resp_data[30];
            state_d = (hcs_q & resp_data[30]) ? StReady : StCmd16;
          end
        end
      end
      StCmd16: begin
        if (resp_to) err_set = ErrTimeout;
        else if (resp_ok) begin
          if (resp_r1 == 8'h00) state_d = StReady;
          else err_set = ErrCmd16;
        end
      end
      StReady: begin
        if (rd_req) begin
          rd_ack_d = 1'b1;
          rd_arg_d = sdhc_q ? rd_addr : {rd_addr[22:0], 9'd0};
          state_d  = StCmd17;
        end
      end
      StCmd17: begin
        if (resp_to) err_set = ErrTimeout;
        else if (resp_ok) begin
          if (resp_r1 == 8'h00) begin
            state_d = StData; data_start_d = 1'b1;
          end else err_set = ErrCmd17;
        end
      end
      StData: begin
        if (data_done) begin
          if (data_err) err_set = ErrData;
          else state_d = StReady;
        end
      end
      StError: ;
      default: state_d = StIdle;
    endcase

    if (err_set != 4'd0) begin
      state_d    = StError;
      err_code_d = err_set;
    end
    if (state_d == StReady) spi_fast_d = 1'b1;

    // A restart abandons any outstanding command and all discovered card state.
    if (start) begin
      state_d      = StPwrup;
      cmd_valid_d  = 1'b0;
      cmd_sent_d   = 1'b0;
      cmd0_cnt_d   = 16'd0;
      acmd_cnt_d   = 16'd0;
      hcs_d        = 1'b0;
      sdhc_d       = 1'b0;
      spi_fast_d   = 1'b0;
      err_code_d   = 4'd0;
      rd_ack_d     = 1'b0;
      data_start_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_27 or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      cmd_valid_q  <= 1'b0;
      cmd_sent_q   <= 1'b0;
      cmd_index_q  <= 6'd0;
      cmd_arg_q    <= 32'd0;
      cmd_crc_q    <= 7'd0;
      cmd_long_q   <= 1'b0;
      rd_arg_q     <= 32'd0;
      wait_cnt_q   <= 32'd0;
      cmd0_cnt_q   <= 16'd0;
      acmd_cnt_q   <= 16'd0;
      hcs_q        <= 1'b0;
      sdhc_q       <= 1'b0;
      spi_fast_q   <= 1'b0;
      err_code_q   <= 4'd0;
      rd_ack_q     <= 1'b0;
      data_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_sent_q   <= cmd_sent_d;
      cmd_index_q  <= cmd_index_d;
      cmd_arg_q    <= cmd_arg_d;
      cmd_crc_q    <= cmd_crc_d;
      cmd_long_q   <= cmd_long_d;
      rd_arg_q     <= rd_arg_d;
      wait_cnt_q   <= wait_cnt_d;
      cmd0_cnt_q   <= cmd0_cnt_d;
      acmd_cnt_q   <= acmd_cnt_d;
      hcs_q        <= hcs_d;
      sdhc_q       <= sdhc_d;
      spi_fast_q   <= spi_fast_d;
      err_code_q   <= err_code_d;
      rd_ack_q     <= rd_ack_d;
      data_start_q <= data_start_d;
    end
  end

  logic unused_resp_data;
  assign unused_resp_data = ^{resp_data[31], resp_data[29:12]};

  assign pwrup_req  = (state_q == StPwrup);
  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;
  assign cmd_arg    = cmd_arg_q;
  assign cmd_crc    = cmd_crc_q;
  assign cmd_long   = cmd_long_q;
  assign spi_fast   = spi_fast_q;
  assign rd_ack     = rd_ack_q;
  assign data_start = data_start_q;
  assign ready      = (state_q == StReady);
  assign error      = (state_q == StError);
  assign busy       = !((state_q == StIdle) || (state_q == StReady) || (state_q == StError));
  assign err_code   = err_code_q;
  assign sdhc       = sdhc_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed scoreboard bench for sd_cmd_sequencer acting as a scripted SPI engine and card.
module tb_sd_cmd_sequencer;

  localparam int unsigned Rw = 2700;

  logic        CLOCK_27 = 1'b0;
  logic        RST, start, pwrup_done, cmd_ready, resp_valid, resp_timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data, rd_addr;
  logic        rd_req, data_done, data_err;
  logic        pwrup_req, cmd_valid, cmd_long, spi_fast, rd_ack, data_start;
  logic        ready, busy, error, sdhc;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic [3:0]  err_code, state_out;

  int vectors = 0;
  int miscompares = 0;
  int valid_rises = 0;
  logic cv_prev = 1'b0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        lng;
  } cmd_t;
  cmd_t exp_q[$];

  sd_cmd_sequencer #(.CMD0_RETRIES(8), .ACMD41_RETRIES(1000), .RETRY_WAIT(Rw)) dut (
    .CLOCK_27(CLOCK_27), .RST(RST), .start(start), .pwrup_req(pwrup_req),
    .pwrup_done(pwrup_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .cmd_long(cmd_long),
    .resp_valid(resp_valid), .resp_timeout(resp_timeout), .resp_r1(resp_r1),
    .resp_data(resp_data), .spi_fast(spi_fast), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .data_start(data_start), .data_done(data_done), .data_err(data_err),
    .ready(ready), .busy(busy), .error(error), .err_code(err_code), .sdhc(sdhc),
    .state_out(state_out)
  );

  always #5 CLOCK_27 = ~CLOCK_27;

  always @(posedge CLOCK_27) begin
    if (cmd_valid && !cv_prev) valid_rises <= valid_rises + 1;
    cv_prev <= cmd_valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLOCK_27);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {cmd_arg, cmd_valid, pwrup_req, rd_ack, data_start, spi_fast, ready, busy, error,
            sdhc, err_code, state_out, cmd_index, cmd_crc, cmd_long};
  endfunction

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                        input logic lng, input int hold, output int gap);
    cmd_t e;
    logic [45:0] seen;
    logic stable;
    exp_q.push_back('{idx: idx, arg: arg, crc: crc, lng: lng});
    gap = 0;
    while (!cmd_valid && gap < 10000) begin
      step();
      gap++;
    end
    e = exp_q.pop_front();
    if (!cmd_valid) begin
      check("cmd_valid wait", 64'(cmd_valid), 64'(1));
      return;
    end
    seen = {cmd_index, cmd_arg, cmd_crc, cmd_long};
    check("cmd fields", 64'(seen), 64'({e.idx, e.arg, e.crc, e.lng}));
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        step();
        if (!cmd_valid || {cmd_index, cmd_arg, cmd_crc, cmd_long} != seen) stable = 1'b0;
      end
      check("hold stable", 64'(stable), 64'(1));
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    if (hold > 0) check("valid drop", 64'(cmd_valid), 64'(0));
    step();
  endtask

  task automatic resp(input logic [7:0] r1, input logic [31:0] d, input logic vld,
                      input logic to);
    resp_r1 = r1;
    resp_data = d;
    resp_valid = vld;
    resp_timeout = to;
    step();
    resp_valid = 1'b0;
    resp_timeout = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pwrup();
    repeat (2) step();
    pwrup_done = 1'b1;
    step();
    pwrup_done = 1'b0;
  endtask

  task automatic read_req(input logic [31:0] a);
    rd_addr = a;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    int g;
    int base;
    RST = 1'b1; start = 0; pwrup_done = 0; cmd_ready = 0; resp_valid = 0; resp_timeout = 0;
    resp_r1 = 0; resp_data = 0; rd_req = 0; rd_addr = 0; data_done = 0; data_err = 0;
    repeat (3) step();
    RST = 1'b0;
    step();
    check("reset outputs", outs(), 64'd0);

    // v2 SDHC card
    pulse_start();
    check("pwrup entry", 64'({state_out, pwrup_req, busy}), 64'({4'h1, 1'b1, 1'b1}));
    pwrup();
    check("cmd0 entry", 64'(state_out), 64'(4'h2));
    do_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 0, g);
    resp(8'h01, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd8, 32'h1AA, 7'h43, 1'b1, 0, g);
    check("gap cmd0-cmd8", 64'(g + 1), 64'(2));
    resp(8'h01, 32'h0000_01AA, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cmd(6'd55, 32'd0, 7'h7F, 1'b0, 0, g);
      if (i > 0) check("acmd41 wait gap", 64'(g + 1), 64'(Rw + 2));
      resp(8'h01, 32'd0, 1'b1, 1'b0);
      do_cmd(6'd41, 32'h4000_0000, 7'h7F, 1'b0, 0, g);
      resp((i < 3) ? 8'h01 : 8'h00, 32'd0, 1'b1, 1'b0);
    end
    do_cmd(6'd58, 32'd0, 7'h7F, 1'b1, 0, g);
    resp(8'h00, 32'hC0FF_8000, 1'b1, 1'b0);
    check("sdhc ready", 64'({state_out, ready, spi_fast, sdhc, busy}),
          64'({4'h9, 1'b1, 1'b1, 1'b1, 1'b0}));

    read_req(32'd5);
    check("rd_ack sdhc", 64'({rd_ack, state_out}), 64'({1'b1, 4'hA}));
    do_cmd(6'd17, 32'd5, 7'h7F, 1'b0, 0, g);
    resp(8'h00, 32'd0, 1'b1, 1'b0);
    check("data_start", 64'({state_out, data_start}), 64'({4'hB, 1'b1}));
    data_done = 1'b1;
    step();
    data_done = 1'b0;
    check("data done ready", 64'({state_out, ready}), 64'({4'h9, 1'b1}));

    // v1 standard-capacity card
    pulse_start();
    check("restart clears", 64'({state_out, spi_fast, sdhc}), 64'({4'h1, 1'b0, 1'b0}));
    pwrup();
    do_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 0, g);
    resp(8'h01, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd8, 32'h1AA, 7'h43, 1'b1, 0, g);
    resp(8'h05, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd55, 32'd0, 7'h7F, 1'b0, 0, g);
    resp(8'h01, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd41, 32'd0, 7'h7F, 1'b0, 0, g);
    resp(8'h00, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd58, 32'd0, 7'h7F, 1'b1, 0, g);
    resp(8'h00, 32'h80FF_8000, 1'b1, 1'b0);
    check("cmd16 entry", 64'(state_out), 64'(4'h8));
    do_cmd(6'd16, 32'd512, 7'h7F, 1'b0, 0, g);
    resp(8'h00, 32'd0, 1'b1, 1'b0);
    check("v1 ready", 64'({state_out, ready, spi_fast, sdhc}), 64'({4'h9, 1'b1, 1'b1, 1'b0}));

    read_req(32'd5);
    do_cmd(6'd17, 32'hA00, 7'h7F, 1'b0, 0, g);
    resp(8'h00, 32'd0, 1'b1, 1'b0);
    data_done = 1'b1;
    data_err = 1'b1;
    step();
    data_done = 1'b0;
    data_err = 1'b0;
    check("data error", 64'({state_out, error, err_code, busy}), 64'({4'hC, 1'b1, 4'd7, 1'b0}));

    rd_req = 1'b1;
    rd_addr = 32'd9;
    step();
    step();
    rd_req = 1'b0;
    check("rd_req ignored", 64'({rd_ack, state_out}), 64'({1'b0, 4'hC}));

    // CMD0 never answers 01
    pulse_start();
    pwrup();
    base = valid_rises;
    for (int i = 0; i < 8; i++) begin
      do_cmd(6'd0, 32'd0, 7'h4A, 1'b0, (i == 0) ? 100 : 0, g);
      resp(8'hFF, 32'd0, 1'b1, 1'b0);
    end
    repeat (20) step();
    check("cmd0 error", 64'({state_out, error, err_code}), 64'({4'hC, 1'b1, 4'd1}));
    check("cmd0 attempts", 64'(valid_rises - base), 64'(8));
    pulse_start();
    check("restart from error", 64'({state_out, error, err_code}), 64'({4'h1, 1'b0, 4'd0}));

    // CMD58 timeout, with a simultaneous resp_valid that must lose
    pwrup();
    do_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 0, g);
    resp(8'h01, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd8, 32'h1AA, 7'h43, 1'b1, 0, g);
    resp(8'h05, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd55, 32'd0, 7'h7F, 1'b0, 0, g);
    resp(8'h01, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd41, 32'd0, 7'h7F, 1'b0, 0, g);
    resp(8'h00, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd58, 32'd0, 7'h7F, 1'b1, 0, g);
    resp(8'h00, 32'hC0FF_8000, 1'b1, 1'b1);
    check("cmd58 timeout", 64'({state_out, error, err_code, sdhc}),
          64'({4'hC, 1'b1, 4'd8, 1'b0}));

    // Asynchronous reset while ACMD41 is being offered
    pulse_start();
    pwrup();
    do_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 0, g);
    resp(8'h01, 32'd0, 1'b1, 1'b0);
    do_cmd(6'd8, 32'h1AA, 7'h43, 1'b1, 0, g);
    resp(8'h01, 32'h0000_01AA, 1'b1, 1'b0);
    do_cmd(6'd55, 32'd0, 7'h7F, 1'b0, 0, g);
    resp(8'h01, 32'd0, 1'b1, 1'b0);
    g = 0;
    while (!cmd_valid && g < 100) begin
      step();
      g++;
    end
    check("acmd41 offered", 64'({cmd_valid, cmd_index, cmd_arg}),
          64'({1'b1, 6'd41, 32'h4000_0000}));
    #2;
    RST = 1'b1;
    #1;
    check("async reset", outs(), 64'd0);
    step();
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
